operand_sum_sequencer: RTL and testbench

//  Sequencer for the multi-operand adder on the lab board. One debounced PB_LOAD button

---
 rtl/operand_sum_sequencer_pkg.sv | 20 ++
 rtl/operand_sum_sequencer_pb_edge_sync.sv | 28 ++
 rtl/operand_sum_sequencer.sv | 142 ++++++++++++++
 tb/tb_operand_sum_sequencer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/operand_sum_sequencer_pkg.sv
// Shared definitions for the operand sum sequencer: FSM state encoding and
// helpers that derive the result and operand-count widths.
package operand_sum_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOAD = 2'b01,
    ST_SUM  = 2'b10,
    ST_DONE = 2'b11
  } state_t;

  function automatic int sum_w_f(input int width, input int num_ops);
    return width + $clog2(num_ops);
  endfunction

  function automatic int cnt_w_f(input int num_ops);
    return $clog2(num_ops + 1);
  endfunction

endpackage

// File: rtl/operand_sum_sequencer_pb_edge_sync.sv
// Push-button conditioner: 2-flop synchronizer followed by a rising-edge detector
// that emits a single-cycle pulse per press, however long the button is held.
module pb_edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic PB,
  output logic PULSE
);

  logic r_sync0;
  logic r_sync1;
  logic r_prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync0 <= 1'b0;
      r_sync1 <= 1'b0;
      r_prev  <= 1'b0;
    end else begin
      r_sync0 <= PB;
      r_sync1 <= r_sync0;
      r_prev  <= r_sync1;
    end
  end

  assign PULSE = r_sync1 & ~r_prev;

endmodule

// File: rtl/operand_sum_sequencer.sv
// Captures NUM_OPS operands from one load button, then sums them one per cycle
// through a single accumulator and presents the result with a DONE flag.
module operand_sum_sequencer
  import operand_sum_sequencer_pkg::*;
#(
  parameter  int WIDTH   = 4,
  parameter  int NUM_OPS = 5,
  localparam int SUM_W   = sum_w_f(WIDTH, NUM_OPS),
  localparam int CNT_W   = cnt_w_f(NUM_OPS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] X,
  input  logic             PB_LOAD,
  input  logic             PB_CLEAR,
  output logic [SUM_W-1:0] Z,
  output logic             DONE,
  output logic             BUSY,
  output logic [CNT_W-1:0] OP_CNT
);

  localparam int IDX_W = (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_OPS - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OPS - 1);

  state_t           r_state;
  state_t           w_next;
  logic             w_load;
  logic             w_clear;
  logic             w_slot_we;
  logic [CNT_W-1:0] w_slot_sel;
  logic [WIDTH-1:0] r_slot [NUM_OPS];
  logic [SUM_W-1:0] r_acc;
  logic [SUM_W-1:0] w_acc_sum;
  logic [SUM_W-1:0] r_z;
  logic [IDX_W-1:0] r_idx;
  logic [CNT_W-1:0] r_cnt;
  logic             r_done;

  pb_edge_sync u_sync_load (
    .clk   (clk),
    .reset (reset),
    .PB    (PB_LOAD),
    .PULSE (w_load)
  );

  pb_edge_sync u_sync_clear (
    .clk   (clk),
    .reset (reset),
    .PB    (PB_CLEAR),
    .PULSE (w_clear)
  );

  assign w_acc_sum = r_acc + SUM_W'(r_slot[r_idx]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Clear overrides every state and any coincident load.
  always_comb begin
    w_next     = r_state;
    w_slot_we  = 1'b0;
    w_slot_sel = '0;
    if (w_clear) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (w_load) begin
            w_next    = ST_LOAD;
            w_slot_we = 1'b1;
          end
        end
        ST_LOAD: begin
          if (w_load) begin
            w_slot_we  = 1'b1;
            w_slot_sel = r_cnt;
            if (r_cnt == LAST_CNT) w_next = ST_SUM;
          end
        end
        ST_SUM: begin
          if (r_idx == LAST_IDX) w_next = ST_DONE;
        end
        default: w_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_OPS; i++) r_slot[i] <= '0;
      r_acc  <= '0;
      r_idx  <= '0;
      r_cnt  <= '0;
      r_z    <= '0;
      r_done <= 1'b0;
    end else begin
      if (w_slot_we) r_slot[w_slot_sel] <= X;
      if (w_clear) begin
        r_acc  <= '0;
        r_idx  <= '0;
        r_cnt  <= '0;
        r_z    <= '0;
        r_done <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE, ST_DONE: begin
            if (w_load) begin
              r_cnt  <= CNT_W'(1);
              r_done <= 1'b0;
            end
          end
          ST_LOAD: begin
            if (w_load) begin
              r_cnt <= r_cnt + CNT_W'(1);
              r_acc <= '0;
              r_idx <= '0;
            end
          end
          ST_SUM: begin
            // Z is only written once with the final total, never a partial sum.
            r_acc <= w_acc_sum;
            r_idx <= r_idx + IDX_W'(1);
            if (r_idx == LAST_IDX) begin
              r_z    <= w_acc_sum;
              r_done <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign Z      = r_z;
  assign DONE   = r_done;
  assign BUSY   = (r_state == ST_SUM);
  assign OP_CNT = r_cnt;

endmodule

// File: tb/tb_operand_sum_sequencer.sv
// Self-checking bench for operand_sum_sequencer: directed scenarios plus random
// load/clear sequences compared against a set-level reference model.
module tb_operand_sum_sequencer;

  localparam int WIDTH   = 4;
  localparam int NUM_OPS = 5;
  localparam int SUM_W   = 7;
  localparam int CNT_W   = 3;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [WIDTH-1:0] X = '0;
  logic             PB_LOAD = 1'b0;
  logic             PB_CLEAR = 1'b0;
  logic [SUM_W-1:0] Z;
  logic             DONE;
  logic             BUSY;
  logic [CNT_W-1:0] OP_CNT;

  int n_cmp = 0;
  int n_mis = 0;

  // Reference model: operands of the current set, last completed sum, done flag.
  int unsigned m_ops[$];
  int unsigned m_z    = 0;
  bit          m_done = 1'b0;

  operand_sum_sequencer dut (
    .clk      (clk),
    .reset    (reset),
    .X        (X),
    .PB_LOAD  (PB_LOAD),
    .PB_CLEAR (PB_CLEAR),
    .Z        (Z),
    .DONE     (DONE),
    .BUSY     (BUSY),
    .OP_CNT   (OP_CNT)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic int unsigned model_sum();
    int unsigned s = 0;
    foreach (m_ops[i]) s += m_ops[i];
    return s;
  endfunction

  task automatic check_outputs(input string tag);
    chk({tag, ".cnt"},  OP_CNT, m_ops.size());
    chk({tag, ".z"},    Z,      m_z);
    chk({tag, ".done"}, DONE,   m_done);
  endtask

  function automatic void model_push(input int unsigned v);
    if (m_done) begin
      m_ops.delete();
      m_done = 1'b0;
    end
    m_ops.push_back(v);
  endfunction

  // Check the SUM window and completion after the final load pulse was consumed.
  task automatic check_sum_phase(input string tag);
    for (int c = 0; c < NUM_OPS; c++) begin
      chk({tag, ".busy"},   BUSY, 1);
      chk({tag, ".zhold"},  Z,    m_z);
      chk({tag, ".nodone"}, DONE, 0);
      if (c < NUM_OPS - 1) tick();
    end
    tick();
    m_z    = model_sum();
    m_done = 1'b1;
    chk({tag, ".busy_end"}, BUSY, 0);
    check_outputs({tag, ".done"});
  endtask

  // One button press: pulse reaches the FSM 3 edges after the raw rise.
  task automatic do_load(input int unsigned v, input string tag);
    X = WIDTH'(v);
    PB_LOAD = 1'b1;
    tick(3);
    PB_LOAD = 1'b0;
    model_push(v);
    chk({tag, ".cnt"}, OP_CNT, m_ops.size());
    if (m_ops.size() == NUM_OPS) begin
      check_sum_phase(tag);
      tick(2);
    end else begin
      check_outputs(tag);
      tick(3);
    end
  endtask

  task automatic do_clear(input string tag);
    PB_CLEAR = 1'b1;
    tick(3);
    PB_CLEAR = 1'b0;
    m_ops.delete();
    m_z    = 0;
    m_done = 1'b0;
    check_outputs(tag);
    chk({tag, ".busy"}, BUSY, 0);
    tick(3);
  endtask

  initial begin
    int unsigned vals1[5] = '{3, 5, 7, 9, 11};
    int unsigned v;

    // Reset state
    tick(2);
    chk("rst.z", Z, 0);
    chk("rst.done", DONE, 0);
    chk("rst.busy", BUSY, 0);
    chk("rst.cnt", OP_CNT, 0);
    reset = 1'b0;
    tick(2);

    // 1: basic set, sum 35
    for (int i = 0; i < 5; i++) do_load(vals1[i], "t1");
    chk("t1.z35", Z, 35);

    // 2: all-max operands, no wrap
    for (int i = 0; i < 5; i++) do_load(15, "t2");
    chk("t2.z75", Z, 75);

    // 3: held button produces exactly one capture
    do_clear("t3.clr");
    X = 4'd6;
    PB_LOAD = 1'b1;
    tick(20);
    PB_LOAD = 1'b0;
    model_push(6);
    chk("t3.cnt_held", OP_CNT, 1);
    tick(3);
    chk("t3.cnt_after", OP_CNT, 1);
    for (int i = 0; i < 4; i++) do_load(i + 1, "t3");
    chk("t3.z16", Z, 16);

    // 4: partial set then clear, then a fresh set
    do_load(2, "t4"); do_load(4, "t4"); do_load(6, "t4");
    do_clear("t4.clr");
    for (int i = 0; i < 5; i++) do_load(1, "t4b");
    chk("t4.z5", Z, 5);

    // 5: asynchronous reset two cycles into SUM
    for (int i = 0; i < 4; i++) do_load(9, "t5");
    X = 4'd9;
    PB_LOAD = 1'b1;
    tick(3);
    PB_LOAD = 1'b0;
    chk("t5.busy_in", BUSY, 1);
    tick(1);
    reset = 1'b1;
    #1;
    chk("t5.rst_z", Z, 0);
    chk("t5.rst_done", DONE, 0);
    chk("t5.rst_busy", BUSY, 0);
    chk("t5.rst_cnt", OP_CNT, 0);
    tick(1);
    reset = 1'b0;
    m_ops.delete();
    m_z = 0;
    m_done = 1'b0;
    tick(8);
    check_outputs("t5.post");
    for (int i = 0; i < 5; i++) do_load(vals1[i], "t5b");
    chk("t5.z35", Z, 35);

    // 6: load during SUM dropped; clear+load together -> clear wins
    for (int i = 0; i < 4; i++) do_load(2, "t6");
    chk("t6.zkeep", Z, 35);
    X = 4'd2;
    PB_LOAD = 1'b1;
    tick(3);
    PB_LOAD = 1'b0;
    model_push(2);
    tick(1);
    X = 4'd15;
    PB_LOAD = 1'b1;     // this pulse lands inside SUM
    tick(1);
    m_z = 35;
    for (int c = 0; c < 3; c++) begin
      chk("t6.busy", BUSY, 1);
      chk("t6.zhold", Z, 35);
      tick();
    end
    m_z = model_sum();
    m_done = 1'b1;
    check_outputs("t6.done");
    chk("t6.z10", Z, 10);
    PB_LOAD = 1'b0;
    tick(4);
    check_outputs("t6.nodrop");
    PB_LOAD = 1'b1;
    PB_CLEAR = 1'b1;
    tick(3);
    PB_LOAD = 1'b0;
    PB_CLEAR = 1'b0;
    m_ops.delete();
    m_z = 0;
    m_done = 1'b0;
    check_outputs("t6.clrwin");
    tick(3);
    check_outputs("t6.clrwin2");

    // Random load/clear sequences
    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(0, 9) < 8) begin
        v = $urandom_range(0, 15);
        do_load(v, "rnd.ld");
      end else begin
        do_clear("rnd.clr");
      end
      if ($urandom_range(0, 3) == 0) tick($urandom_range(1, 4));
      check_outputs("rnd.idle");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
